// File: rtl/mem_if_pkg.sv
// Shared types and address decode for the memory responder.
// Imported by the responder top and the testbench.
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    localparam int WORD_BYTES = 4;
    localparam int WORD_SHIFT = $clog2(WORD_BYTES);

    typedef struct packed {
        logic        err;
        logic [31:0] idx;
    } addr_dec_t;

    // Flags misaligned or out-of-range addresses; addr must be zero-extended by the caller.
    function automatic addr_dec_t decode_addr(input logic [63:0] addr, input int idx_w);
        addr_dec_t   dec;
        logic [63:0] mask;
        mask    = (64'd1 << idx_w) - 64'd1;
        dec.idx = 32'((addr >> WORD_SHIFT) & mask);
        dec.err = (addr[WORD_SHIFT-1:0] != '0) || ((addr >> (idx_w + WORD_SHIFT)) != 64'd0);
        return dec;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the core's memory controller and the responder.
// Handshake: a request transfers on a rising edge where req_valid && req_ready; rsp_valid is a
// single-cycle strobe with no backpressure, so the initiator must be waiting for it.
interface mem_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_array.sv
// Word-addressed backing store: synchronous write, asynchronous read, contents not reset.
module mem_array #(
    parameter int DEPTH_WORDS = 64,
    parameter int DATA_W      = 32,
    localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one word request, waits WAIT_CYCLES, performs the access,
// then returns a one-cycle response strobe on leaving RESP.
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    mem_responder_if.slave bus,
    output mem_state_e dbg_state_o
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    mem_state_e        state_q;
    logic [3:0]        cnt_q;
    logic              we_q;
    logic              err_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] rd_d;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    addr_dec_t         req_dec;
    logic [IDX_W-1:0]  req_idx;
    logic              unused_idx_hi;
    logic              req_ready;
    logic              req_fire;

    logic              acc_go;
    logic              acc_we;
    logic              acc_err;
    logic [IDX_W-1:0]  acc_idx;
    logic [DATA_W-1:0] acc_wdata;
    logic [DATA_W-1:0] mem_rdata;

    assign req_dec       = decode_addr(64'(bus.req_addr), IDX_W);
    assign req_idx       = req_dec.idx[IDX_W-1:0];
    assign unused_idx_hi = ^req_dec.idx[31:IDX_W];

    assign req_ready = reset && (state_q == IDLE);
    assign req_fire  = bus.req_valid && req_ready;

    // The access happens on the edge that enters RESP; with no wait states that edge is
    // the acceptance edge itself, so the live request fields are used instead of the holds.
    always_comb begin
        acc_go    = 1'b0;
        acc_we    = we_q;
        acc_err   = err_q;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        if (state_q == IDLE) begin
            if ((WAIT_CYCLES == 0) && req_fire) begin
                acc_go    = 1'b1;
                acc_we    = bus.req_we;
                acc_err   = req_dec.err;
                acc_idx   = req_idx;
                acc_wdata = bus.req_wdata;
            end
        end else if ((state_q == WAIT) && (cnt_q == 4'd0)) begin
            acc_go = 1'b1;
        end
    end

    assign rd_d = (acc_we || acc_err) ? '0 : mem_rdata;

    mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .DATA_W     (DATA_W)
    ) u_array (
        .clk    (clk),
        .we_i   (acc_go && acc_we && !acc_err),
        .addr_i (acc_idx),
        .wdata_i(acc_wdata),
        .rdata_o(mem_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            if (acc_go) begin
                rd_q <= rd_d;
            end
            unique case (state_q)
                IDLE: begin
                    if (req_fire) begin
                        we_q    <= bus.req_we;
                        err_q   <= req_dec.err;
                        idx_q   <= req_idx;
                        wdata_q <= bus.req_wdata;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= RESP;
                        end else begin
                            cnt_q   <= CNT_INIT;
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= rd_q;
                    rsp_err_q   <= err_q;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a default (2 wait state) instance and a zero-wait instance
// share one stimulus driver; sel picks which one is driven and observed.
module tb_mem_responder;
    import mem_if_pkg::*;

    logic clk;
    logic reset;
    logic sel;
    logic req_valid;
    logic req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rdy;
    logic        rsp_v;
    logic [31:0] rsp_d;
    logic        rsp_e;
    mem_state_e  dbg0;
    mem_state_e  dbg1;

    int n_cmp = 0;
    int n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    mem_responder_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    assign bus0.req_valid = req_valid && !sel;
    assign bus0.req_we    = req_we;
    assign bus0.req_addr  = req_addr;
    assign bus0.req_wdata = req_wdata;
    assign bus1.req_valid = req_valid && sel;
    assign bus1.req_we    = req_we;
    assign bus1.req_addr  = req_addr;
    assign bus1.req_wdata = req_wdata;

    assign rdy   = sel ? bus1.req_ready : bus0.req_ready;
    assign rsp_v = sel ? bus1.rsp_valid : bus0.rsp_valid;
    assign rsp_d = sel ? bus1.rsp_rdata : bus0.rsp_rdata;
    assign rsp_e = sel ? bus1.rsp_err   : bus0.rsp_err;

    mem_responder #(.WAIT_CYCLES(2)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave), .dbg_state_o(dbg0)
    );
    mem_responder #(.WAIT_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave), .dbg_state_o(dbg1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One complete transaction; inputs go to junk right after acceptance.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd,
                          input logic exp_err, input int exp_lat);
        int n;
        int lat;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        n = 0;
        while (!rdy && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_ready"}, 32'(rdy), 32'd1);
        @(negedge clk);
        req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF;
        lat = 0;
        while (!rsp_v && lat < 20) begin @(negedge clk); lat++; end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, rsp_d, exp_rd);
        chk({tag, "_err"}, 32'(rsp_e), 32'(exp_err));
        @(negedge clk);
        chk({tag, "_drop"}, {30'd0, rsp_v, rsp_e}, 32'd0);
        chk({tag, "_dropd"}, rsp_d, 32'd0);
    endtask

    initial begin
        int lat;
        int pulses;
        logic [5:0] rp;
        logic [5:0] vp;
        logic [31:0] d2;

        reset = 1'b0; sel = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(rdy), 32'd0);
        chk("rst_rsp", {30'd0, rsp_v, rsp_e}, 32'd0);
        chk("rst_rdata", rsp_d, 32'd0);
        chk("rst_state", 32'(dbg0), 32'(IDLE));
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(rdy), 32'd1);

        do_req("wr10", 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 3);
        do_req("rd10", 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);

        do_req("rd13", 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 3);
        do_req("wr20", 1'b1, 32'h20, 32'h1234_5678, 32'h0, 1'b0, 3);
        do_req("wr22", 1'b1, 32'h22, 32'h1, 32'h0, 1'b1, 3);
        do_req("rd20", 1'b0, 32'h20, 32'h0, 32'h1234_5678, 1'b0, 3);

        do_req("wr00", 1'b1, 32'h0, 32'hA5A5_0000, 32'h0, 1'b0, 3);
        do_req("wr100", 1'b1, 32'h100, 32'hFFFF_FFFF, 32'h0, 1'b1, 3);
        do_req("rd00", 1'b0, 32'h0, 32'h0, 32'hA5A5_0000, 1'b0, 3);

        // Busy ignore: second request held on the bus while the first is in flight.
        do_req("wr04", 1'b1, 32'h04, 32'h0404_0404, 32'h0, 1'b0, 3);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_wdata = '0;
        chk("busy_ready0", 32'(rdy), 32'd1);
        @(negedge clk);
        req_addr = 32'h04;
        chk("busy_wait_ready", 32'(rdy), 32'd0);
        lat = 0;
        while (!rsp_v && lat < 20) begin @(negedge clk); lat++; end
        chk("busy_first_lat", 32'(lat), 32'd3);
        chk("busy_first_rdata", rsp_d, 32'hDEAD_BEEF);
        chk("busy_ready_back", 32'(rdy), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_v && lat < 20) begin @(negedge clk); lat++; end
        chk("busy_second_lat", 32'(lat), 32'd3);
        chk("busy_second_rdata", rsp_d, 32'h0404_0404);

        // Reset in the middle of a write.
        do_req("wr08", 1'b1, 32'h08, 32'h1111_2222, 32'h0, 1'b0, 3);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h08; req_wdata = 32'h55AA_55AA;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_state_wait", 32'(dbg0), 32'(WAIT));
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(rdy), 32'd0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_v) pulses++;
            chk("mid_rst_ready_hold", 32'(rdy), 32'd0);
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_v) pulses++;
        end
        chk("mid_no_rsp", 32'(pulses), 32'd0);
        chk("mid_idle", 32'(dbg0), 32'(IDLE));
        chk("mid_ready", 32'(rdy), 32'd1);
        do_req("rd08", 1'b0, 32'h08, 32'h0, 32'h1111_2222, 1'b0, 3);

        // Zero-wait instance.
        sel = 1'b1;
        do_req("w0_wr30", 1'b1, 32'h30, 32'hCAFE_F00D, 32'h0, 1'b0, 1);
        do_req("w0_rd30", 1'b0, 32'h30, 32'h0, 32'hCAFE_F00D, 1'b0, 1);
        do_req("w0_rd_oor", 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 1);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h30;
        rp = '0; vp = '0; d2 = '0;
        for (int i = 0; i < 6; i++) begin
            rp[i] = rdy;
            vp[i] = rsp_v;
            if (i == 2) d2 = rsp_d;
            if (i < 5) @(negedge clk);
        end
        req_valid = 1'b0;
        chk("w0_b2b_ready", 32'(rp), 32'(6'b010101));
        chk("w0_b2b_rsp", 32'(vp), 32'(6'b010100));
        chk("w0_b2b_rdata", d2, 32'hCAFE_F00D);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the multicycle core's shared instruction/data memory interface. The core's controller acts as initiator; this block accepts one word request at a time. It inserts a fixed number of wait states, then performs the read or write and returns a single-cycle response. The controller holds in its memory state until the response arrives, so the block models realistic memory latency in place of a zero-wait combinational RAM.

Parameters:
ADDR_W, 32, byte-address width of req_addr
DATA_W, 32, word width
DEPTH_WORDS, 64, number of words in the backing array (power of two)
WAIT_CYCLES, 2, wait states between acceptance and response (0..15)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
req_valid  input  1  initiator presents a request
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  byte address, word-aligned expected
req_wdata  input  DATA_W  write data
req_ready  output  1  responder can accept a request this cycle
rsp_valid  output  1  one-cycle response strobe (read data or write ack)
rsp_rdata  output  DATA_W  read data, valid with rsp_valid
rsp_err  output  1  request was misaligned or out of range, valid with rsp_valid

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous, active-low, named reset; clock is clk.
- States: IDLE, WAIT, RESP. Reset forces IDLE.
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
- req_ready = (state==IDLE) while reset is deasserted. It is 0 while reset is asserted.
- Backing-array contents are not reset.
- IDLE: on req_valid && req_ready, capture we/addr/wdata into holding registers.
  - If WAIT_CYCLES>0, load counter with WAIT_CYCLES-1 and go to WAIT.
  - If WAIT_CYCLES==0, go directly to RESP.
- WAIT: decrement counter each cycle. When counter==0, go to RESP.
- Transition into RESP performs the access:
  - Write: array[word] <= wdata.
  - Read: register array[word] into rsp_rdata.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. No response backpressure; the initiator must be waiting.
- Latency: request accepted at edge N gives rsp_valid high in the cycle after edge N+1+WAIT_CYCLES. With the default of 2, the response appears 3 cycles after acceptance.
- Throughput: one request per WAIT_CYCLES+2 cycles. req_ready is low in WAIT and RESP. req_valid in those states is ignored and not queued.
- Word index = addr[log2(DEPTH_WORDS)+1:2].
- Error rule: rsp_err=1 if addr[1:0]!=0 or addr[ADDR_W-1:log2(DEPTH_WORDS)+2]!=0.
  - On error: no array write, rsp_rdata=0, response still issued with normal latency.
- rsp_rdata on a write response = 0. rsp_rdata and rsp_err return to 0 when rsp_valid drops.
- Reset asserted mid-transaction: pending request discarded, no array write if not yet performed, no response, IDLE after release.
- Captured request fields are stable from acceptance to response; later changes on req_* have no effect.

Decomposition:
- Package mem_if_pkg holds:
  - state encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2
  - WORD_BYTES=4
  - a function computing word index and the range/alignment error from addr
- Sub-module mem_array: DEPTH_WORDS x DATA_W, synchronous write, asynchronous read, no reset. The responder instantiates it once.

Test Plan:
- Write then read, default params: write addr=0x10, wdata=0xDEADBEEF; then read addr=0x10 -> write rsp_valid 3 cycles after acceptance with rsp_err=0; read returns rsp_rdata=0xDEADBEEF, rsp_err=0.
- Misaligned: read addr=0x13 -> rsp_valid with rsp_err=1, rsp_rdata=0. Write addr=0x22 wdata=0x1 followed by read 0x20 -> prior contents unchanged.
- Out of range (DEPTH_WORDS=64): write addr=0x100 -> rsp_err=1. Read 0x000 -> not aliased/overwritten.
- Busy ignore: hold req_valid high with a second request (read 0x04) during WAIT -> only the first request is answered. The second is accepted only on the cycle req_ready returns to 1, and answered with 0x04 contents.
- WAIT_CYCLES=0 build: read accepted at edge N -> rsp_valid in cycle after edge N+1. Back-to-back requests are accepted every 2 cycles.
- Reset mid-operation: accept write addr=0x08 wdata=0x55AA55AA, assert reset (0) during WAIT -> rsp_valid never pulses, req_ready=0 during reset, IDLE and req_ready=1 after release. A later read of 0x08 returns the pre-reset value, not 0x55AA55AA.
